// File: rtl/mux_arbiter_if.sv
// Handshake/data bundle between the three requesters and the mux arbiter.
// The requester side drives req and the data bytes. The arbiter drives grant, mux controls and the muxed byte.
interface mux_arbiter_if;
  logic [2:0] req;
  logic [7:0] alpha;
  logic [7:0] beta;
  logic [7:0] gamma;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       cs;
  logic [7:0] out;

  modport master (output req, alpha, beta, gamma, input gnt, sel, cs, out);
  modport slave  (input req, alpha, beta, gamma, output gnt, sel, cs, out);
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin arbiter for three requesters sharing an 8-bit mux output.
// Each owner's tenure is bounded while others wait. Grant, sel and cs come only from flops.
module mux_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_arbiter_if.slave    bus
);
  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(HOLD_MAX - 1);

  typedef enum logic {IDLE, OWN} state_e;

  state_e          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      last_q,  last_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [2:0]      own_oh, others;
  logic [2:0][7:0] data;

  function automatic logic [1:0] rr_next(input logic [1:0] i);
    case (i)
      2'd0:    rr_next = 2'd1;
      2'd1:    rr_next = 2'd2;
      default: rr_next = 2'd0;
    endcase
  endfunction

  // Searches last+1, last+2, last+3 (mod 3) and returns the first set bit of mask.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] mask);
    logic [1:0] c;
    logic       found;
    rr_pick = 2'd0;
    c       = last;
    found   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      c = rr_next(c);
      if (!found && mask[c]) begin
        rr_pick = c;
        found   = 1'b1;
      end
    end
  endfunction

  assign own_oh = 3'b001 << owner_q;
  assign others = bus.req & ~own_oh;
  assign data   = {bus.gamma, bus.beta, bus.alpha};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = OWN;
          owner_d = rr_pick(last_q, bus.req);
          cnt_d   = '0;
        end
      end
      default: begin
        if (!bus.req[owner_q]) begin
          last_d = owner_q;
          cnt_d  = '0;
          if (|others) owner_d = rr_pick(owner_q, others);
          else         state_d = IDLE;
        end else if (cnt_q == CMAX && |others) begin
          // Expired owner is excluded here; it competes again next round.
          last_d  = owner_q;
          owner_d = rr_pick(owner_q, others);
          cnt_d   = '0;
        end else if (cnt_q != CMAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_comb begin
    bus.gnt = 3'b000;
    bus.sel = 2'd3;
    bus.cs  = 1'b0;
    if (state_q == OWN) begin
      bus.gnt = own_oh;
      bus.sel = owner_q;
      bus.cs  = 1'b1;
    end
  end

  always_comb begin
    bus.out = 8'h00;
    if (bus.cs && bus.sel != 2'd3) bus.out = data[bus.sel];
  end
endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter with HOLD_MAX=4: reset, contention, release, round-robin, mid-tenure reset.
module tb_mux_arbiter;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  mux_arbiter_if bus();

  mux_arbiter #(.HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [2:0] g, input logic [1:0] s,
                         input logic c, input logic [7:0] o);
    chk({tag, ".gnt"}, 32'(bus.gnt), 32'(g));
    chk({tag, ".sel"}, 32'(bus.sel), 32'(s));
    chk({tag, ".cs"},  32'(bus.cs),  32'(c));
    chk({tag, ".out"}, 32'(bus.out), 32'(o));
  endtask

  initial begin
    logic [2:0] g;
    rst_n     = 1'b0;
    bus.req   = 3'b111;
    bus.alpha = 8'hA1;
    bus.beta  = 8'h5B;
    bus.gamma = 8'hC3;

    // Reset held two edges with all requests pending
    for (int i = 0; i < 2; i++) begin
      step();
      chk_out("reset", 3'b000, 2'd3, 1'b0, 8'h00);
    end
    rst_n = 1'b1;

    // Full contention: alpha x4, beta x4, gamma x4, alpha x4
    for (int i = 0; i < 16; i++) begin
      step();
      case (i / 4)
        1:       g = 3'b010;
        2:       g = 3'b100;
        default: g = 3'b001;
      endcase
      chk("contention.gnt", 32'(bus.gnt), 32'(g));
      chk("contention.cs",  32'(bus.cs),  32'd1);
    end
    chk("contention.out_alpha", 32'(bus.out), 32'hA1);

    // Single requester beta for 10 cycles
    bus.req = 3'b010;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_out("single", 3'b010, 2'd1, 1'b1, 8'h5B);
    end
    bus.req = 3'b000;
    step();
    chk_out("drop_idle", 3'b000, 2'd3, 1'b0, 8'h00);
    step();
    chk_out("stay_idle", 3'b000, 2'd3, 1'b0, 8'h00);

    // Round-robin pointer: last owner beta, so gamma wins over alpha
    bus.req = 3'b101;
    step();
    chk_out("rr_gamma", 3'b100, 2'd2, 1'b1, 8'hC3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_gamma_hold.gnt", 32'(bus.gnt), 32'b100);
    end
    step();
    chk_out("rr_alpha", 3'b001, 2'd0, 1'b1, 8'hA1);

    // Early release: alpha drops after 2 cycles with only gamma pending
    step();
    chk("early_alpha2.gnt", 32'(bus.gnt), 32'b001);
    bus.req = 3'b100;
    step();
    chk_out("early_gamma", 3'b100, 2'd2, 1'b1, 8'hC3);
    bus.gamma = 8'h7E;
    #1;
    chk("live_out", 32'(bus.out), 32'h7E);
    // Tenure restarted: gamma still holds 3 more cycles against alpha
    bus.req = 3'b101;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("restart_hold.gnt", 32'(bus.gnt), 32'b100);
    end
    step();
    chk("restart_handover.gnt", 32'(bus.gnt), 32'b001);

    // Gamma takes over and reaches cnt=2 without competition
    bus.req = 3'b100;
    step();
    chk("g_own.gnt", 32'(bus.gnt), 32'b100);
    step();
    step();
    chk("g_cnt2.gnt", 32'(bus.gnt), 32'b100);

    // Mid-tenure reset pulse
    rst_n   = 1'b0;
    bus.req = 3'b111;
    step();
    chk_out("mid_reset", 3'b000, 2'd3, 1'b0, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_reset_alpha.gnt", 32'(bus.gnt), 32'b001);
    end
    step();
    chk_out("post_reset_beta", 3'b010, 2'd1, 1'b1, 8'h5B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter and sequencer for the 3-input, 8-bit chip-selected mux datapath. Three requesters (alpha, beta, gamma) each raise a request line. The block grants the shared output to one requester at a time, drives the mux `sel`/`cs` controls from registered state, and exposes the muxed byte. A tenure limit stops any one requester from monopolising the output while others wait.

## Interface
- `HOLD_MAX`, default 4: maximum consecutive granted cycles for one owner while another requester is pending. Legal range is ≥1.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset. **Synchronous, active-low.**
- `req` in 3: request lines. Bit 0 is alpha, bit 1 is beta, bit 2 is gamma.
- `alpha` in 8: data from requester 0.
- `beta` in 8: data from requester 1.
- `gamma` in 8: data from requester 2.
- `gnt` out 3: one-hot grant, registered. All zero when idle.
- `sel` out 2: registered mux select.
  - 0 = alpha, 1 = beta, 2 = gamma.
  - 3 when idle.
- `cs` out 1: registered chip select. High exactly when `gnt` is nonzero.
- `out` out 8: combinational function of registered `sel`/`cs` and the live data inputs.
  - `cs=1`: `out` equals the input selected by `sel`.
  - Otherwise `out` is 0.

## Operation
- States:
  - IDLE: `cs=0`, `gnt=000`, `sel=3`.
  - OWN: one owner granted.
- Internal state:
  - `last` (2 bits): previous owner. Reset value is 2.
  - `cnt`: width $clog2(HOLD_MAX+1), counts the owner's granted cycles.
- Round-robin search order is `last+1`, `last+2`, `last+3` (mod 3). The first requester found with `req` high wins.
- IDLE → OWN at an edge where `req != 0`.
  - The winner is loaded as owner and `cnt` is set to 0.
  - `gnt`, `sel` and `cs` update at that edge.
- At each edge in OWN, with owner `o`:
  - **Release:** `req[o]=0`. Set `last=o` and re-arbitrate among the remaining requesters at the same edge.
    - If another request is pending, hand over directly to it, with `cnt=0` and no idle cycle.
    - Otherwise go to IDLE.
  - **Tenure expiry:** `cnt==HOLD_MAX-1` and some other `req` bit is high. Set `last=o` and hand over to the round-robin winner among the others, with `cnt=0`. The owner's still-high request is reconsidered only in later rounds.
  - **Otherwise:** stay OWN and increment `cnt`. `cnt` saturates at `HOLD_MAX-1`. With no competition, the owner keeps the grant indefinitely, and a late competitor takes over at the first edge it is seen.
- `HOLD_MAX=1`: ownership alternates every cycle among all active requesters.
- `gnt` is always one-hot or zero. `sel` and `cs` are always consistent with `gnt`.
- The block buffers no data. `out` tracks the owner's live input within the same cycle.

## Timing
- **Reset** (`rst_n` low at an edge) applies at that edge, including mid-tenure:
  - `gnt=000`, `sel=3`, `cs=0`, `out=0`.
  - `cnt=0`, `last=2`, state IDLE.
- **Request-to-grant latency:** 1 edge. A `req` high during cycle N gives `gnt`/`cs`/`sel` valid in cycle N+1. `out` is valid in that same cycle N+1.
- **Release latency:** a `req` drop during cycle N removes the grant in cycle N+1. The owner must not assume its data is consumed after its request falls.
- **Handover:** zero bubble cycles between owners when requests overlap.
- **Tenure:** with continuous competition, each owner holds exactly `HOLD_MAX` cycles.
- **Simultaneous requests after reset:** order is alpha, then beta, then gamma.

## Test plan
1. **Reset with requests pending.** Hold `rst_n=0` for 2 cycles with `req=111`, `alpha=8'hA1`.
   - During reset: `gnt=000`, `sel=3`, `cs=0`, `out=0`.
   - First edge after release: `gnt=001`, `sel=0`, `out=8'hA1`.
2. **Single requester, no competition.** `req=010` for 10 cycles, `HOLD_MAX=4`, `beta=8'h5B`.
   - `gnt=010` and `out=8'h5B` continuously, no gaps.
   - Drop `req` → `gnt=000` and `out=0` after the next edge.
3. **Full contention.** `req=111` constant, `HOLD_MAX=4`.
   - Grant sequence: alpha ×4, beta ×4, gamma ×4, alpha ×4.
   - `cs` stays high throughout, with no idle cycle.
4. **Early release.** Alpha owns; alpha drops `req` after 2 cycles while `req[2]=1` and `req[1]=0`.
   - Next edge: `gnt=100`, `sel=2`, `out=gamma`, tenure count restarted.
5. **Round-robin pointer.** Beta owns and releases to IDLE; later `req=101`.
   - Gamma is granted first, then alpha after gamma's tenure or release.
6. **Mid-tenure reset.** Gamma owns with `cnt=2`; pulse `rst_n` low for 1 cycle.
   - Outputs go to reset values at that edge.
   - With `req=111` afterwards, alpha is granted first and holds a full 4 cycles.
